// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// uart_tx_stream : valid/ready fed UART transmitter (start, LSB-first data,
//                  optional parity, 1-2 stop bits). Revision 1.0
// ============================================================================
module uart_tx_stream #(
  parameter int C_DATA_WIDTH   = 8,
  parameter int C_CLKS_PER_BIT = 16,
  parameter int C_PARITY       = 0,
  parameter int C_STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  output logic                    tx,
  output logic                    busy
);

  localparam int BAUD_W = $clog2(C_CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(C_DATA_WIDTH);

  localparam logic [BAUD_W-1:0] C_LAST_BAUD = BAUD_W'(C_CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_LAST_DATA = BIT_W'(C_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  C_LAST_STOP = BIT_W'(C_STOP_BITS - 1);
  localparam logic              C_ODD       = (C_PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  r_state, w_state;
  logic [BAUD_W-1:0]       r_baud, w_baud;
  logic [BIT_W-1:0]        r_bit, w_bit;
  logic [C_DATA_WIDTH-1:0] r_shift, w_shift;
  logic                    r_parity, w_parity;
  logic                    r_tx, w_tx;
  logic                    r_busy, w_busy;
  logic                    r_ready, w_ready;
  logic                    w_baud_done;

  assign w_baud_done = (r_baud == C_LAST_BAUD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_baud   <= w_baud;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_parity <= w_parity;
      r_tx     <= w_tx;
      r_busy   <= w_busy;
      r_ready  <= w_ready;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_baud   = r_baud;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_parity = r_parity;
    w_tx     = r_tx;
    w_busy   = r_busy;
    w_ready  = r_ready;

    // Baud counter restarts at the transfer edge so every bit boundary is CPB cycles from it
    if (r_state != S_IDLE) begin
      w_baud = w_baud_done ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_ready = 1'b1;
        w_baud  = '0;
        w_bit   = '0;
        if (in_valid && r_ready) begin
          w_state  = S_START;
          w_tx     = 1'b0;
          w_busy   = 1'b1;
          w_ready  = 1'b0;
          w_shift  = in_data;
          w_parity = (^in_data) ^ C_ODD;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state = S_DATA;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit == C_LAST_DATA) begin
            w_bit = '0;
            if (C_PARITY != 0) begin
              w_state = S_PARITY;
              w_tx    = r_parity;
            end else begin
              w_state = S_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit   = r_bit + 1'b1;
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_baud_done) begin
          w_state = S_STOP;
          w_tx    = 1'b1;
          w_bit   = '0;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_bit == C_LAST_STOP) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_ready = 1'b1;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_ready = 1'b0;
      end
    endcase
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign in_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// tb_uart_tx_stream : directed checks of framing, parity, handshake, back-to-back,
// FIFO-fed operation and mid-frame reset of uart_tx_stream (CPB = 4).
module tb_uart_tx_stream;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy_n, tx_n, busy_n;
  logic       rdy_e, tx_e, busy_e;
  logic       rdy_o, tx_o, busy_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic       dec_en   = 1'b1;
  int         acc_q[$];
  int         start_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(CPB), .C_PARITY(0), .C_STOP_BITS(1)) dut_none (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_n),
    .in_data(in_data), .tx(tx_n), .busy(busy_n));

  uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(CPB), .C_PARITY(1), .C_STOP_BITS(1)) dut_even (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_e),
    .in_data(in_data), .tx(tx_e), .busy(busy_e));

  uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(CPB), .C_PARITY(2), .C_STOP_BITS(1)) dut_odd (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_o),
    .in_data(in_data), .tx(tx_o), .busy(busy_o));

  // Transfer log for the no-parity instance, stamped with the edge's cycle number
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && rdy_n) acc_q.push_back(cyc);
  end

  // Mid-bit sampling decoder on the no-parity line
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (dec_en && resetn && tx_n === 1'b0) begin
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_n;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_bit(input int mode, input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (mode != 0 && idx == 9) return (mode == 1) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    chk_eq("rx_count", rx_q.size(), n);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int         bad_tx, bad_busy, wi, full_rises;
    logic       full, prev_full, hs, do_wr;
    logic [7:0] msg[3];
    msg = '{8'h61, 8'h62, 8'h63};

    // Reset state
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_eq("rst_tx", tx_n, 1'b1);
    chk_eq("rst_ready", rdy_n, 1'b0);
    chk_eq("rst_busy", busy_n, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    chk_eq("ready_after_rst", rdy_n, 1'b1);

    // Idle hold
    acc_q.delete();
    bad_tx   = 0;
    bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_n !== 1'b1) bad_tx++;
      if (busy_n !== 1'b0) bad_busy++;
    end
    chk_eq("idle_tx_low_cycles", bad_tx, 0);
    chk_eq("idle_busy_cycles", bad_busy, 0);
    chk_eq("idle_transfers", acc_q.size(), 0);

    // Single frame 'a' on all three parity modes, with upstream noise mid-frame
    rx_q.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h61;
    @(posedge clk);
    for (int k = 0; k <= 44; k++) begin
      @(negedge clk);
      in_valid = (k < 36) && (k % 3 == 1);
      in_data  = 8'($urandom);
      chk_eq($sformatf("none_tx[%0d]", k), tx_n, exp_bit(0, 8'h61, k / CPB));
      chk_eq($sformatf("none_ready[%0d]", k), rdy_n, k >= 40);
      chk_eq($sformatf("none_busy[%0d]", k), busy_n, k < 40);
      chk_eq($sformatf("even_tx[%0d]", k), tx_e, exp_bit(1, 8'h61, k / CPB));
      chk_eq($sformatf("even_ready[%0d]", k), rdy_e, k >= 44);
      chk_eq($sformatf("odd_tx[%0d]", k), tx_o, exp_bit(2, 8'h61, k / CPB));
      chk_eq($sformatf("odd_busy[%0d]", k), busy_o, k < 44);
    end
    in_valid = 1'b0;
    chk_eq("single_decoded", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h61);

    // Back-to-back "bc"
    repeat (20) @(negedge clk);
    acc_q.delete();
    rx_q.delete();
    start_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h62;
    for (int i = 0; i < 20 && acc_q.size() < 1; i++) @(negedge clk);
    in_data = 8'h63;
    for (int i = 0; i < 80 && acc_q.size() < 2; i++) @(negedge clk);
    in_valid = 1'b0;
    wait_rx(2, 120);
    repeat (20) @(negedge clk);
    chk_eq("b2b_transfers", acc_q.size(), 2);
    chk_eq("b2b_accept_gap", (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1, 41);
    chk_eq("b2b_start_gap", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 41);
    chk_eq("b2b_start_latency", (start_q.size() > 0 && acc_q.size() > 0) ? start_q[0] - acc_q[0] : -1, 1);
    chk_eq("b2b_byte0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h62);
    chk_eq("b2b_byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h63);

    // Depth-3 FIFO feeding the transmitter with "abc"
    repeat (60) @(negedge clk);
    acc_q.delete();
    rx_q.delete();
    fifo_q.delete();
    wi         = 0;
    full_rises = 0;
    prev_full  = 1'b0;
    for (int c = 0; c < 300 && rx_q.size() < 3; c++) begin
      @(negedge clk);
      full = (fifo_q.size() == 3);
      if (full && !prev_full) full_rises++;
      prev_full = full;
      in_valid  = (fifo_q.size() != 0);
      in_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      hs        = in_valid && rdy_n;
      do_wr     = (wi < 3) && !full;
      @(posedge clk);
      if (hs) void'(fifo_q.pop_front());
      if (do_wr) begin
        fifo_q.push_back(msg[wi]);
        wi++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_eq("fifo_rx_count", rx_q.size(), 3);
    chk_eq("fifo_byte0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h61);
    chk_eq("fifo_byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h62);
    chk_eq("fifo_byte2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'h63);
    chk_eq("fifo_full_at_most_once", full_rises <= 1, 1'b1);
    chk_eq("fifo_empty_after", fifo_q.size(), 0);
    chk_eq("fifo_transfers", acc_q.size(), 3);

    // Reset during data bit 3 of 0x30 (that bit is 0 on the line)
    repeat (60) @(negedge clk);
    dec_en = 1'b0;
    acc_q.delete();
    send(8'h30);
    repeat (17) @(negedge clk);
    chk_eq("pre_rst_tx_d3", tx_n, 1'b0);
    chk_eq("pre_rst_busy", busy_n, 1'b1);
    resetn = 1'b0;
    #1;
    chk_eq("async_rst_tx", tx_n, 1'b1);
    chk_eq("async_rst_busy", busy_n, 1'b0);
    chk_eq("async_rst_ready", rdy_n, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_ready", rdy_n, 1'b1);
    rx_q.delete();
    acc_q.delete();
    dec_en = 1'b1;
    send(8'h4B);
    wait_rx(1, 120);
    repeat (20) @(negedge clk);
    chk_eq("post_rst_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h4B);
    chk_eq("post_rst_frames", rx_q.size(), 1);
    chk_eq("post_rst_transfers", acc_q.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
